ser2par_framer: RTL and testbench
=================================

Name: ser2par_framer

Overview:
Downstream consumer of the single-bit serial delay/shift chain output (its q3 stream). Hunts the bit stream for a sync word, then assembles the following bits MSB-first into WIDTH-bit words. It emits each word with a one-cycle valid pulse, and returns to hunting after a fixed number of words per frame.

Parameters:
WIDTH, 8, word width in bits and sync-word width (>=2)
SYNC_WORD, 8'hA5, frame sync pattern (WIDTH bits, MSB received first)
FRAME_WORDS, 4, data words per frame after sync (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
din  input  1  serial data bit (from the shift-chain output)
din_en  input  1  din qualifier; a bit is consumed only on cycles with din_en=1
locked  output  1  1 while in LOCKED state
data_out  output  WIDTH  last assembled word, held until the next word
data_valid  output  1  one-cycle pulse, data_out updated this cycle
frame_end  output  1  one-cycle pulse, coincident with data_valid of the last word of a frame
word_cnt  output  $clog2(FRAME_WORDS+1)  words delivered in the current frame
parity_err  output  1  one-cycle pulse on parity failure (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge): state=HUNT, locked=0, data_out=0, data_valid=0, frame_end=0, word_cnt=0, parity_err=0, window=0, fill count=0, bit_cnt=0. Reset overrides din_en and takes effect mid-word or mid-frame with no partial word output.
- Cycles with din_en=0: no state, counter or shift change. Pulse outputs deassert.
- data_valid, frame_end and parity_err are registered pulses, 1 cycle wide, and are 0 on every other cycle.
- HUNT state:
  - Each consumed bit updates window <= {window[WIDTH-2:0], din} and fill <= min(fill+1, WIDTH).
  - Match condition: the new window equals SYNC_WORD and the new fill equals WIDTH. In other words, a match needs at least WIDTH bits received since entering HUNT; this prevents stale data bits from matching.
  - On match: next cycle state=LOCKED, locked=1, bit_cnt=0, word_cnt=0.
  - Overlapping candidate patterns are handled naturally by the sliding window.
- LOCKED state:
  - Each consumed bit updates shreg <= {shreg[WIDTH-2:0], din} and bit_cnt++.
  - On the consumed bit where bit_cnt==WIDTH-1: next cycle data_out={shreg[WIDTH-2:0],din}, data_valid=1, bit_cnt=0, word_cnt++.
  - Latency: data_valid is high the cycle after the clk edge that samples the word's last bit.
  - When the delivered word is word FRAME_WORDS (word_cnt reaches FRAME_WORDS):
    - frame_end=1 in the same cycle as data_valid.
    - state=HUNT, locked=0, fill=0, window=0.
    - word_cnt holds FRAME_WORDS until the next sync match clears it.
- No backpressure: the consumer must accept data_valid pulses. Words are never dropped or buffered.
- data_out is never cleared except by rst.

Optional Feature:
PARITY_CHECK_EN
- Defined:
  - Each data word is followed by one even-parity bit. bit_cnt counts 0..WIDTH, and the parity bit is consumed at bit_cnt==WIDTH.
  - Parity passes if XOR(word bits, parity bit)==0. On pass: data_valid (and frame_end if applicable) is asserted the cycle after the parity bit, with data_out updated as above.
  - On fail:
    - parity_err=1 for one cycle.
    - data_valid=0 and data_out is unchanged.
    - frame_end=0.
    - state=HUNT, locked=0, fill=0, word_cnt=0.
- Undefined: no parity bit is expected, and parity_err is tied to 0.

Test Plan:
1. Reset and idle: rst=1 for 2 cycles, then din_en=0 for 10 cycles -> all outputs 0, locked=0.
2. Sync and frame (20 ns clk, din_en=1, parity off):
   - Stimulus: 3 junk bits 0,1,1, then A5, then words 3C,FF,00,81.
   - Required: locked rises 1 cycle after the last sync bit.
   - Required: data_valid pulses 4 times with data_out=3C,FF,00,81, the first pulse 8 cycles after locked rises.
   - Required: frame_end coincides with 81, then locked=0 and word_cnt=4.
3. din_en gaps: same stream with din_en=0 on every other cycle -> identical word values, each pulse delayed proportionally. No extra pulses occur.
4. Stale-match guard:
   - Stimulus: frame whose last word is A5, immediately followed by 5 more bits.
   - Required: no relock until 8 fresh bits equal A5. Sending A5 again relocks.
5. Mid-word reset: rst=1 after 4 bits of word 2 -> next cycle locked=0, data_out=0, no data_valid. The next A5 relocks with word_cnt=0.
6. PARITY_CHECK_EN defined:
   - Stimulus: A5, then 3C+parity 0, then 01+parity 0.
   - Required: data_valid for 3C, then parity_err pulse, locked=0, data_out stays 3C.

Source files
------------

// File: rtl/ser2par_framer.sv
// ser2par_framer: hunts a serial bit stream for SYNC_WORD, then assembles
// FRAME_WORDS words of WIDTH bits (MSB first) and returns to hunting.
// Optional build macro PARITY_CHECK_EN: each data word is followed by an
// even-parity bit; a failed check drops the word and forces a re-hunt.
module ser2par_framer #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      SYNC_WORD   = WIDTH'(8'hA5),
    parameter int unsigned           FRAME_WORDS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 din,
    input  logic                                 din_en,
    output logic                                 locked,
    output logic [WIDTH-1:0]                     data_out,
    output logic                                 data_valid,
    output logic                                 frame_end,
    output logic [$clog2(FRAME_WORDS+1)-1:0]     word_cnt,
    output logic                                 parity_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned WC_W  = $clog2(FRAME_WORDS + 1);
`ifdef PARITY_CHECK_EN
    localparam int unsigned SH_W  = WIDTH;
`else
    localparam int unsigned SH_W  = WIDTH - 1;
`endif

    typedef enum logic {
        S_HUNT   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [WIDTH-1:0]   r_window,   w_window_nxt;
    logic [CNT_W-1:0]   r_fill,     w_fill_nxt;
    logic [SH_W-1:0]    r_shreg,    w_shreg_nxt;
    logic [CNT_W-1:0]   r_bit_cnt,  w_bit_cnt_nxt;
    logic [WIDTH-1:0]   r_data_out, w_data_nxt;
    logic [WC_W-1:0]    r_word_cnt, w_wc_nxt;
    logic               r_locked;
    logic               r_valid,    w_valid_nxt;
    logic               r_fe,       w_fe_nxt;
    logic               r_perr,     w_perr_nxt;

    logic [WIDTH-1:0]   w_word;
    logic [WC_W-1:0]    w_wc_inc;
    logic               w_last;

    // Word formed by the held bits plus the bit arriving this cycle
    assign w_word   = {r_shreg[WIDTH-2:0], din};
    assign w_wc_inc = r_word_cnt + WC_W'(1);
    assign w_last   = (w_wc_inc == WC_W'(FRAME_WORDS));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_HUNT;
            r_window   <= '0;
            r_fill     <= '0;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_data_out <= '0;
            r_word_cnt <= '0;
            r_locked   <= 1'b0;
            r_valid    <= 1'b0;
            r_fe       <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_window   <= w_window_nxt;
            r_fill     <= w_fill_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_data_out <= w_data_nxt;
            r_word_cnt <= w_wc_nxt;
            r_locked   <= (w_state_nxt == S_LOCKED);
            r_valid    <= w_valid_nxt;
            r_fe       <= w_fe_nxt;
            r_perr     <= w_perr_nxt;
        end
    end

    // Next-state logic: sync hunt, word assembly, frame termination
    always_comb begin
        w_state_nxt   = r_state;
        w_window_nxt  = r_window;
        w_fill_nxt    = r_fill;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_data_nxt    = r_data_out;
        w_wc_nxt      = r_word_cnt;
        w_valid_nxt   = 1'b0;
        w_fe_nxt      = 1'b0;
        w_perr_nxt    = 1'b0;

        if (din_en) begin
            case (r_state)
                S_HUNT: begin
                    w_window_nxt = {r_window[WIDTH-2:0], din};
                    if (r_fill != CNT_W'(WIDTH)) begin
                        w_fill_nxt = r_fill + CNT_W'(1);
                    end
                    // Fill guard keeps bits from before this hunt out of the match
                    if ((w_window_nxt == SYNC_WORD) && (w_fill_nxt == CNT_W'(WIDTH))) begin
                        w_state_nxt   = S_LOCKED;
                        w_bit_cnt_nxt = '0;
                        w_wc_nxt      = '0;
                    end
                end
                S_LOCKED: begin
`ifdef PARITY_CHECK_EN
                    if (r_bit_cnt == CNT_W'(WIDTH)) begin
                        // Parity bit: the word stays in shreg, parity is not shifted in
                        w_bit_cnt_nxt = '0;
                        if ((^{r_shreg, din}) == 1'b0) begin
                            w_data_nxt  = r_shreg;
                            w_valid_nxt = 1'b1;
                            w_wc_nxt    = w_wc_inc;
                            if (w_last) begin
                                w_fe_nxt     = 1'b1;
                                w_state_nxt  = S_HUNT;
                                w_window_nxt = '0;
                                w_fill_nxt   = '0;
                            end
                        end else begin
                            w_perr_nxt   = 1'b1;
                            w_state_nxt  = S_HUNT;
                            w_window_nxt = '0;
                            w_fill_nxt   = '0;
                            w_wc_nxt     = '0;
                        end
                    end else begin
                        w_shreg_nxt   = w_word[SH_W-1:0];
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
`else
                    w_shreg_nxt = w_word[SH_W-1:0];
                    if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
                        w_bit_cnt_nxt = '0;
                        w_data_nxt    = w_word;
                        w_valid_nxt   = 1'b1;
                        w_wc_nxt      = w_wc_inc;
                        if (w_last) begin
                            w_fe_nxt     = 1'b1;
                            w_state_nxt  = S_HUNT;
                            w_window_nxt = '0;
                            w_fill_nxt   = '0;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
`endif
                end
            endcase
        end
    end

    assign locked     = r_locked;
    assign data_out   = r_data_out;
    assign data_valid = r_valid;
    assign frame_end  = r_fe;
    assign word_cnt   = r_word_cnt;
`ifdef PARITY_CHECK_EN
    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ser2par_framer.sv
// Testbench for ser2par_framer: table of frames plus hand-written corner
// sequences; delivered words are checked against a scoreboard queue.
module tb_ser2par_framer;

    localparam int unsigned W    = 8;
    localparam int unsigned FW   = 4;
    localparam int unsigned WC_W = $clog2(FW + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            din;
    logic            din_en;
    logic            locked;
    logic [W-1:0]    data_out;
    logic            data_valid;
    logic            frame_end;
    logic [WC_W-1:0] word_cnt;
    logic            parity_err;

    ser2par_framer #(
        .WIDTH      (W),
        .SYNC_WORD  (8'hA5),
        .FRAME_WORDS(FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_en     (din_en),
        .locked     (locked),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_end  (frame_end),
        .word_cnt   (word_cnt),
        .parity_err (parity_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       fe;
    } exp_t;

    typedef struct {
        logic [31:0]     words;
        int              gap;
        logic [WC_W-1:0] exp_wc;
        logic            exp_locked;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[3];
    int   checks = 0;
    int   errors = 0;
    bit   perr_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every data_valid pops one expected word
    always @(negedge clk) begin
        if (data_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=%0h expected=none at %0t", data_out, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("data_out", 32'(data_out), 32'(mon_e.data));
                chk("frame_end", 32'(frame_end), 32'(mon_e.fe));
            end
        end else if (frame_end) begin
            chk("frame_end_without_valid", 32'(frame_end), 32'd0);
        end
        if (parity_err && !perr_ok) begin
            chk("parity_err_spurious", 32'(parity_err), 32'd0);
        end
    end

    task automatic send_bit(input logic b, input int gap);
        din    = b;
        din_en = 1'b1;
        @(posedge clk); #1;
        din_en = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic [7:0] w, input int gap, input bit is_data, input bit fe);
        if (is_data) sb.push_back('{w, fe});
        for (int i = 7; i >= 0; i--) send_bit(w[i], gap);
`ifdef PARITY_CHECK_EN
        if (is_data) send_bit(^w, gap);
`endif
    endtask

    task automatic send_frame(input logic [31:0] words, input int gap);
        send_bit(1'b0, gap);
        send_bit(1'b1, gap);
        send_bit(1'b1, gap);
        send_word(8'hA5, gap, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send_word(words[31-8*k -: 8], gap, 1'b1, k == 3);
    endtask

    initial begin
        rst    = 1'b1;
        din    = 1'b0;
        din_en = 1'b0;
        vecs[0] = '{32'h3CFF0081, 1, WC_W'(4), 1'b0};
        vecs[1] = '{32'h12345678, 2, WC_W'(4), 1'b0};
        vecs[2] = '{32'hA55AFF01, 0, WC_W'(4), 1'b0};

        // Reset and idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_locked", 32'(locked), 32'd0);
        chk("idle_data_out", 32'(data_out), 32'd0);
        chk("idle_valid", 32'(data_valid), 32'd0);
        chk("idle_frame_end", 32'(frame_end), 32'd0);
        chk("idle_word_cnt", 32'(word_cnt), 32'd0);
        chk("idle_parity_err", 32'(parity_err), 32'd0);

        // Sync and frame with exact latency checks
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        begin
            logic [7:0] s;
            s = 8'hA5;
            for (int i = 7; i >= 1; i--) send_bit(s[i], 0);
            chk("pre_sync_locked", 32'(locked), 32'd0);
            send_bit(s[0], 0);
            chk("sync_locked", 32'(locked), 32'd1);
            chk("sync_word_cnt", 32'(word_cnt), 32'd0);
        end
        send_word(8'h3C, 0, 1'b1, 1'b0);
        chk("first_valid_latency", 32'(data_valid), 32'd1);
        send_word(8'hFF, 0, 1'b1, 1'b0);
        send_word(8'h00, 0, 1'b1, 1'b0);
        send_word(8'h81, 0, 1'b1, 1'b1);
        chk("frame_end_pulse", 32'(frame_end), 32'd1);
        chk("post_frame_locked", 32'(locked), 32'd0);
        chk("post_frame_word_cnt", 32'(word_cnt), 32'd4);

        // Table of frames, including din_en gaps
        foreach (vecs[v]) begin
            send_frame(vecs[v].words, vecs[v].gap);
            repeat (3) @(posedge clk);
            #1;
            chk("row_sb_empty", 32'(sb.size()), 32'd0);
            chk("row_word_cnt", 32'(word_cnt), 32'(vecs[v].exp_wc));
            chk("row_locked", 32'(locked), 32'(vecs[v].exp_locked));
        end

        // Stale-match guard: frame ending in A5 then fresh bits
        send_frame(32'h112233A5, 0);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        chk("stale_no_relock", 32'(locked), 32'd0);
        begin
            logic [7:0] s;
            s = 8'hA5;
            for (int i = 7; i >= 1; i--) send_bit(s[i], 0);
            chk("fresh_partial_no_lock", 32'(locked), 32'd0);
            send_bit(s[0], 0);
            chk("fresh_relock", 32'(locked), 32'd1);
        end

        // Mid-word reset
        send_word(8'h5C, 0, 1'b1, 1'b0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        send_word(8'hA5, 0, 1'b0, 1'b0);
        chk("rst_relock", 32'(locked), 32'd1);
        chk("rst_relock_word_cnt", 32'(word_cnt), 32'd0);
        send_word(8'hDE, 0, 1'b1, 1'b0);
        send_word(8'hAD, 0, 1'b1, 1'b0);
        send_word(8'hBE, 0, 1'b1, 1'b0);
        send_word(8'hEF, 0, 1'b1, 1'b1);
        chk("rst_frame_word_cnt", 32'(word_cnt), 32'd4);

`ifdef PARITY_CHECK_EN
        // Parity failure drops the word and returns to hunting
        send_word(8'hA5, 0, 1'b0, 1'b0);
        send_word(8'h3C, 0, 1'b1, 1'b0);
        begin
            logic [7:0] bad;
            bad = 8'h01;
            for (int i = 7; i >= 0; i--) send_bit(bad[i], 0);
        end
        perr_ok = 1'b1;
        send_bit(1'b0, 0);
        chk("perr_pulse", 32'(parity_err), 32'd1);
        chk("perr_valid", 32'(data_valid), 32'd0);
        chk("perr_locked", 32'(locked), 32'd0);
        chk("perr_data_out", 32'(data_out), 32'h3C);
        chk("perr_word_cnt", 32'(word_cnt), 32'd0);
        @(posedge clk); #1;
        chk("perr_one_cycle", 32'(parity_err), 32'd0);
        perr_ok = 1'b0;
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
